// File: rtl/booth_mult_seq.sv
// booth_mult_seq: iterative Booth multiplier with valid/ready on both sides.
// Retires one Booth digit per clock over a (WIDTH+2)-bit datapath, so the
// same hardware serves signed and unsigned operands exactly.
// Build option: define BOOTH_SEQ_RADIX4_EN for radix-4 recoding (two multiplier
// bits per cycle, WIDTH must be even); leave it undefined for radix-2.
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [WIDTH-1:0]     i_m,
    input  logic [WIDTH-1:0]     i_q,
    input  logic                 i_signed,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [2*WIDTH-1:0]   o_p
);

    // Two guard bits let an unsigned operand look like a positive signed one
    // and keep the accumulator from overflowing on the -2^(W-1) corner.
    localparam int E = WIDTH + 2;
`ifdef BOOTH_SEQ_RADIX4_EN
    localparam int ITER = E / 2;
`else
    localparam int ITER = E;
`endif
    // ITER is at least 2 for any legal WIDTH, so this is never zero.
    localparam int CW = $clog2(ITER);

    if (WIDTH < 2) begin : g_width_min
        $error("booth_mult_seq: WIDTH must be at least 2");
    end
`ifdef BOOTH_SEQ_RADIX4_EN
    if (WIDTH % 2 != 0) begin : g_width_even
        $error("booth_mult_seq: WIDTH must be even for radix-4 recoding");
    end
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [E-1:0]    a_q;
    logic [E-1:0]    q_q;
    logic            qm1_q;
    logic [E-1:0]    m_q;
    logic            sgn_q;

    logic [E-1:0]    m_ext;
    logic [E-1:0]    q_ext;
    logic [E-1:0]    a_nxt;
    logic [E-1:0]    q_nxt;
    logic            qm1_nxt;
    logic [2*E-1:0]  aq_nxt;

    // Operand extension: sign or zero fill decided by the mode bit at accept.
    always_comb begin
        m_ext = i_signed ? {{2{i_m[WIDTH-1]}}, i_m} : {2'b00, i_m};
        q_ext = i_signed ? {{2{i_q[WIDTH-1]}}, i_q} : {2'b00, i_q};
    end

`ifdef BOOTH_SEQ_RADIX4_EN
    logic [E:0] a_x;
    logic [E:0] m_x;
    logic [E:0] sum4;

    // Radix-4 step: recode {Q[1:0], q_-1} into 0/+-M/+-2M, add on E+1 bits,
    // then shift the whole {A,Q,q_-1} register right arithmetically by two.
    always_comb begin
        a_x  = {a_q[E-1], a_q};
        m_x  = {m_q[E-1], m_q};
        sum4 = a_x;
        case ({q_q[1:0], qm1_q})
            3'b001, 3'b010: sum4 = a_x + m_x;
            3'b011:         sum4 = a_x + (m_x << 1);
            3'b100:         sum4 = a_x - (m_x << 1);
            3'b101, 3'b110: sum4 = a_x - m_x;
            default:        sum4 = a_x;
        endcase
        a_nxt   = {sum4[E], sum4[E:2]};
        q_nxt   = {sum4[1:0], q_q[E-1:2]};
        qm1_nxt = q_q[1];
        aq_nxt  = {a_nxt, q_nxt};
    end
`else
    logic [E-1:0] sum2;

    // Radix-2 step: add or subtract M per {Q[0], q_-1}, then shift the whole
    // {A,Q,q_-1} register right arithmetically by one.
    always_comb begin
        sum2 = a_q;
        case ({q_q[0], qm1_q})
            2'b01:   sum2 = a_q + m_q;
            2'b10:   sum2 = a_q - m_q;
            default: sum2 = a_q;
        endcase
        a_nxt   = {sum2[E-1], sum2[E-1:1]};
        q_nxt   = {sum2[0], q_q[E-1:1]};
        qm1_nxt = q_q[0];
        aq_nxt  = {a_nxt, q_nxt};
    end
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next state and handshake outputs; DONE never hands straight to CALC.
    always_comb begin
        state_d = state_q;
        o_ready = 1'b0;
        o_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) state_d = S_CALC;
            end
            S_CALC: begin
                if (cnt_q == '0) state_d = S_DONE;
            end
            S_DONE: begin
                o_valid = 1'b1;
                if (i_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: load at accept, step during CALC, capture product on the last step.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
            a_q   <= '0;
            q_q   <= '0;
            qm1_q <= 1'b0;
            m_q   <= '0;
            sgn_q <= 1'b0;
            o_p   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_valid) begin
                        m_q   <= m_ext;
                        q_q   <= q_ext;
                        a_q   <= '0;
                        qm1_q <= 1'b0;
                        sgn_q <= i_signed;
                        cnt_q <= CW'(ITER - 1);
                    end
                end
                S_CALC: begin
                    a_q   <= a_nxt;
                    q_q   <= q_nxt;
                    qm1_q <= qm1_nxt;
                    if (cnt_q == '0) o_p   <= aq_nxt[2*WIDTH-1:0];
                    else             cnt_q <= cnt_q - CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: directed, self-checking bench for booth_mult_seq at WIDTH=8.
// Expected latency follows BOOTH_SEQ_RADIX4_EN the same way the design does.
`timescale 1ns/1ps
module tb_booth_mult_seq;

`ifdef BOOTH_SEQ_RADIX4_EN
    localparam int ITER = 5;
`else
    localparam int ITER = 10;
`endif

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [7:0]  i_m = 8'h00;
    logic [7:0]  i_q = 8'h00;
    logic        i_signed = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [15:0] o_p;

    int errors = 0;
    int checks = 0;

    booth_mult_seq #(.WIDTH(8)) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_m      (i_m),
        .i_q      (i_q),
        .i_signed (i_signed),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_p      (o_p)
    );

    always #5 i_clk = ~i_clk;

    // Present one operand pair, then wait (bounded) for o_valid.
    task automatic run_txn(input logic [7:0] m, input logic [7:0] q, input logic s,
                           output logic [15:0] p, output int lat);
        i_m = m; i_q = q; i_signed = s; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        lat = 0;
        while (o_valid !== 1'b1 && lat < 100) begin
            @(posedge i_clk); #1;
            lat++;
        end
        p = o_p;
    endtask

    task automatic release_txn();
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        checks++;
        if ({o_ready, o_valid, o_p} !== {1'b1, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL reset_state: ready=%b valid=%b p=%h, want ready=1 valid=0 p=0000",
                     o_ready, o_valid, o_p);
        end
    endtask

    task automatic test_signed_corner();
        logic [15:0] p; int lat;
        run_txn(8'h80, 8'h80, 1'b1, p, lat);
        checks++;
        if (lat !== ITER) begin
            errors++; $display("FAIL corner_latency: got %0d, want %0d", lat, ITER);
        end
        checks++;
        if (p !== 16'h4000) begin
            errors++; $display("FAIL corner_product: got %h, want 4000", p);
        end
        release_txn();
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            errors++; $display("FAIL corner_release: ready=%b valid=%b, want 1/0", o_ready, o_valid);
        end
    endtask

    task automatic test_unsigned_max();
        logic [15:0] p; int lat;
        run_txn(8'hFF, 8'hFF, 1'b0, p, lat);
        checks++;
        if (p !== 16'hFE01) begin
            errors++; $display("FAIL unsigned_max: got %h, want fe01", p);
        end
        release_txn();
        run_txn(8'hFF, 8'h01, 1'b1, p, lat);
        checks++;
        if (p !== 16'hFFFF) begin
            errors++; $display("FAIL signed_minus_one: got %h, want ffff", p);
        end
        release_txn();
        // -128 * 127 signed and 128 * 128 unsigned round out the extremes
        run_txn(8'h7F, 8'h80, 1'b1, p, lat);
        checks++;
        if (p !== 16'hC080) begin
            errors++; $display("FAIL signed_7f_x_80: got %h, want c080", p);
        end
        release_txn();
        run_txn(8'h80, 8'h80, 1'b0, p, lat);
        checks++;
        if (p !== 16'h4000) begin
            errors++; $display("FAIL unsigned_80_x_80: got %h, want 4000", p);
        end
        release_txn();
    endtask

    task automatic test_mode_contrast();
        logic [15:0] p; int lat;
        run_txn(8'h80, 8'h02, 1'b0, p, lat);
        checks++;
        if (p !== 16'h0100) begin
            errors++; $display("FAIL mode_unsigned: got %h, want 0100", p);
        end
        release_txn();
        run_txn(8'h80, 8'h02, 1'b1, p, lat);
        checks++;
        if (p !== 16'hFF00) begin
            errors++; $display("FAIL mode_signed: got %h, want ff00", p);
        end
        checks++;
        if (lat !== ITER) begin
            errors++; $display("FAIL mode_latency: got %0d, want %0d", lat, ITER);
        end
        release_txn();
    endtask

    task automatic test_backpressure();
        logic [15:0] p; int lat; int bad;
        run_txn(8'h0C, 8'h0B, 1'b0, p, lat);
        checks++;
        if (p !== 16'h0084) begin
            errors++; $display("FAIL bp_product: got %h, want 0084", p);
        end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge i_clk); #1;
            if (o_p !== 16'h0084 || o_valid !== 1'b1 || o_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL bp_hold: %0d unstable cycles, want 0 (last p=%h valid=%b)", bad, o_p, o_valid);
        end
        release_txn();
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_p !== 16'h0084) begin
            errors++; $display("FAIL bp_release: ready=%b valid=%b p=%h, want 1/0/0084", o_ready, o_valid, o_p);
        end
    endtask

    task automatic test_busy_inputs();
        int lat; int extra;
        i_m = 8'h03; i_q = 8'h05; i_signed = 1'b0; i_valid = 1'b1;
        @(posedge i_clk); #1;
        lat = 0;
        while (o_valid !== 1'b1 && lat < 100) begin
            i_valid = lat[0];
            i_m = 8'h55; i_q = 8'h33; i_signed = 1'b1;
            @(posedge i_clk); #1;
            lat++;
        end
        i_valid = 1'b0;
        checks++;
        if (o_p !== 16'h000F || lat !== ITER) begin
            errors++; $display("FAIL busy_product: got %h lat %0d, want 000f lat %0d", o_p, lat, ITER);
        end
        release_txn();
        extra = 0;
        for (int i = 0; i < ITER + 3; i++) begin
            @(posedge i_clk); #1;
            if (o_valid === 1'b1 || o_ready !== 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++; $display("FAIL busy_single_txn: %0d stray cycles, want 0", extra);
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [15:0] p; int lat; int stray;
        i_m = 8'h09; i_q = 8'h09; i_signed = 1'b0; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        checks++;
        if (o_ready !== 1'b0) begin
            errors++; $display("FAIL abort_busy: ready=%b, want 0", o_ready);
        end
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        checks++;
        if ({o_ready, o_valid, o_p} !== {1'b1, 1'b0, 16'h0000}) begin
            errors++; $display("FAIL abort_state: ready=%b valid=%b p=%h, want 1/0/0000", o_ready, o_valid, o_p);
        end
        stray = 0;
        for (int i = 0; i < ITER + 3; i++) begin
            @(posedge i_clk); #1;
            if (o_valid === 1'b1) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++; $display("FAIL abort_no_valid: %0d valid cycles, want 0", stray);
        end
        run_txn(8'h07, 8'hFD, 1'b1, p, lat);
        checks++;
        if (p !== 16'hFFEB) begin
            errors++; $display("FAIL after_abort: got %h, want ffeb", p);
        end
        release_txn();
    endtask

    initial begin
        test_reset();
        test_signed_corner();
        test_unsigned_max();
        test_mode_contrast();
        test_backpressure();
        test_busy_inputs();
        test_reset_mid_calc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/booth_mult_seq.md
# booth_mult_seq

Iterative, parametrised Booth multiplier with a valid/ready handshake on both sides. It selects signed or unsigned operation per transaction and retires one Booth digit per clock. It is the sequential, area-lean successor to the array-style Booth multiplier, intended for datapaths where one multiplier is shared across many cycles. A preprocessor switch chooses radix-2 or radix-4 recoding.

## Interface
- `WIDTH`, default 8: operand width in bits.
  - Minimum 2.
  - Must be even when radix-4 is compiled in.
- `i_clk`, input, 1: clock. All state updates on the rising edge.
- `i_reset`, input, 1: reset, synchronous and active-high.
- `i_valid`, input, 1: upstream has an operand pair.
- `o_ready`, output, 1: block accepts operands. High only in IDLE.
- `i_m`, input, WIDTH: multiplicand.
- `i_q`, input, WIDTH: multiplier.
- `i_signed`, input, 1: 1 means two's-complement operands, 0 means unsigned. Sampled with the operands.
- `o_valid`, output, 1: product available. High only in DONE.
- `i_ready`, input, 1: downstream accepts the product.
- `o_p`, output, 2*WIDTH: product, registered.

## Operation
- **Extension at accept**
  - Operands extend to E = WIDTH+2 bits.
  - Sign-extend if `i_signed`=1, else zero-extend.
  - Extended multiplicand M, extended multiplier Q, and the `i_signed` value are registered.
- **Datapath**
  - Accumulator/multiplier shift register of 2E+1 bits: {A[E-1:0], Q[E-1:0], q_-1}.
  - A and q_-1 clear at accept.
- **Radix-2 step** (examine Q[0], q_-1)
  - 01: A += M.
  - 10: A -= M.
  - 00 and 11: no add.
  - Then arithmetic-shift the whole register right by 1.
- **Radix-4 step** (examine Q[1:0], q_-1)
  - 001/010: +M.
  - 011: +2M.
  - 100: −2M.
  - 101/110: −M.
  - 000/111: 0.
  - Adder is E+1 bits wide. Then arithmetic-shift right by 2.
- **Iteration count**
  - ITER = E for radix-2.
  - ITER = E/2 for radix-4.
- **Result**
  - `o_p` = low 2*WIDTH bits of the final {A,Q}.
  - Exact for every signed and unsigned operand pair, including −2^(WIDTH−1) × −2^(WIDTH−1).
- **FSM states**
  - IDLE: `o_ready`=1. When `i_valid`=1, load the operands and go to CALC; iteration counter = ITER−1.
  - CALC: one step per cycle. When the counter reaches 0, perform the final step, register `o_p`, and go to DONE. Otherwise decrement the counter.
  - DONE: `o_valid`=1 and `o_p` is held stable. When `i_ready`=1, go to IDLE.
- **Ignored inputs and held outputs**
  - Inputs (`i_valid`, `i_m`, `i_q`, `i_signed`) are ignored outside IDLE. Operand changes during CALC do not affect the result.
  - `o_p` keeps its last product after DONE until the next product is written.

## Timing
- **Reset values**
  - State IDLE.
  - `o_ready`=1, `o_valid`=0, `o_p`=0.
  - Counter and datapath registers 0.
- **Reset priority**
  - `i_reset` has priority in every state.
  - Asserting it in CALC or DONE aborts the transaction. No `o_valid` pulse follows.
- **Latency**
  - Accept on edge T. `o_valid` is high after edge T+ITER.
  - For WIDTH=8: 10 cycles radix-2, 5 cycles radix-4.
- **Release and throughput**
  - Product is released on the edge where `o_valid`=1 and `i_ready`=1.
  - `o_ready` is high the following cycle.
  - Best-case throughput is one product per ITER+2 cycles.
  - No accept in the release cycle: no bypass from DONE to CALC.
- **Backpressure**
  - `i_ready` may stay low indefinitely. `o_p` and `o_valid` hold.
- **Handshake combinations**
  - `i_valid`=1 while `o_ready`=0: no effect.
  - Upstream must hold operands until `o_ready`=1.

## Configuration
- `BOOTH_SEQ_RADIX4_EN`
  - Defined: radix-4 recoding, two multiplier bits per cycle, ITER=(WIDTH+2)/2. Elaboration fails via a static assertion if WIDTH is odd.
  - Undefined: radix-2 recoding, one bit per cycle, ITER=WIDTH+2, any WIDTH≥2.
  - Interface, handshake and results are identical in both builds. Only latency differs.

## Test plan
All scenarios use WIDTH=8 and run in both macro builds.
- **Signed corner:** signed, m=0x80, q=0x80 → `o_p`=0x4000, `o_valid` exactly ITER cycles after accept.
- **Unsigned maximum:** unsigned, m=0xFF, q=0xFF → `o_p`=0xFE01. Then signed, m=0xFF, q=0x01 → `o_p`=0xFFFF.
- **Mode contrast:** m=0x80, q=0x02 → unsigned gives 0x0100, signed gives 0xFF00.
- **Backpressure:** hold `i_ready`=0 for 6 cycles in DONE. `o_p` stays stable and `o_valid` stays 1. Raise `i_ready` → `o_ready`=1 on the next cycle.
- **Busy-time inputs:** toggle `i_valid` and change `i_m` to 0x55 during CALC of 3×5 → result 0x000F. Only one transaction completes.
- **Reset mid-CALC:** pulse `i_reset` mid-CALC → next cycle `o_ready`=1, `o_valid`=0, `o_p`=0. A following 7×(−3) signed → 0xFFEB.
